// File: rtl/atm_pin_entry.sv
// atm_pin_entry: keypad PIN collector/verifier feeding the ATM controller.
// Collects BCD digits and compares them with the stored PIN. Drives pin_out
// to 4'b1111 after a match and to 4'b0000 otherwise. Counts failed attempts
// and locks the card out after MAX_TRIES failures.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; pin_out holds the last result
// COLLECT | assembling digits, watching the inter-key timeout
// CHECK   | one-cycle compare of the buffer against PIN_CODE
// LOCK    | attempts exhausted; every start pulses pin_bad
module atm_pin_entry #(
  parameter int                        PIN_DIGITS  = 4,
  parameter logic [4*PIN_DIGITS-1:0]   PIN_CODE    = 16'h1234,
  parameter int                        MAX_TRIES   = 3,
  parameter int                        TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       card_clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] pin_out,
  output logic       pin_ok,
  output logic       pin_bad,
  output logic       locked,
  output logic       busy,
  output logic [2:0] digit_cnt
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [2:0]    FULL_CNT     = 3'(PIN_DIGITS);
  localparam logic [2:0]    MAX_T        = 3'(MAX_TRIES);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCK    = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] buffer;
  logic [2:0]    tries;
  logic [TW-1:0] timer;
  logic          timed_out;

  logic          full;
  logic          accept_digit;
  logic          accept_clear;
  logic          accept_enter;
  logic [BW+3:0] shifted;
  logic [2:0]    tries_next;
  logic          match;

  // Key classification; only keys that change the entry count as accepted
  // and reload the inter-key timer.
  assign full         = (digit_cnt == FULL_CNT);
  assign accept_digit = key_valid && (key_code <= 4'd9) && !full;
  assign accept_clear = key_valid && (key_code == 4'hA);
  assign accept_enter = key_valid && (key_code == 4'hB) && full;
  assign shifted      = {buffer, key_code};
  assign tries_next   = (tries == MAX_T) ? tries : tries + 3'd1;
  // A timeout is a failure even if the buffer happens to hold the PIN.
  assign match        = !timed_out && (buffer == PIN_CODE);

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      buffer    <= '0;
      digit_cnt <= '0;
      tries     <= '0;
      timer     <= '0;
      timed_out <= 1'b0;
      pin_out   <= 4'b0000;
      pin_ok    <= 1'b0;
      pin_bad   <= 1'b0;
      locked    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pin_ok  <= 1'b0;
      pin_bad <= 1'b0;
      if (card_clr) begin
        state     <= S_IDLE;
        buffer    <= '0;
        digit_cnt <= '0;
        tries     <= '0;
        timer     <= '0;
        timed_out <= 1'b0;
        pin_out   <= 4'b0000;
        locked    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_COLLECT;
              buffer    <= '0;
              digit_cnt <= '0;
              timer     <= TIMER_RELOAD;
              timed_out <= 1'b0;
              pin_out   <= 4'b0000;
              busy      <= 1'b1;
            end
          end
          S_COLLECT: begin
            if (accept_digit) begin
              buffer    <= shifted[BW-1:0];
              digit_cnt <= digit_cnt + 3'd1;
              timer     <= TIMER_RELOAD;
            end else if (accept_clear) begin
              buffer    <= '0;
              digit_cnt <= '0;
              timer     <= TIMER_RELOAD;
            end else if (accept_enter) begin
              state <= S_CHECK;
            end else if (timer == '0) begin
              state     <= S_CHECK;
              timed_out <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_CHECK: begin
            buffer    <= '0;
            digit_cnt <= '0;
            timed_out <= 1'b0;
            busy      <= 1'b0;
            if (match) begin
              pin_ok  <= 1'b1;
              pin_out <= 4'b1111;
              tries   <= '0;
              state   <= S_IDLE;
            end else begin
              pin_bad <= 1'b1;
              tries   <= tries_next;
              if (tries_next == MAX_T) begin
                state  <= S_LOCK;
                locked <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_LOCK: begin
            if (start) begin
              pin_bad <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: a directed table, hand sequences for the
// multi-cycle corners, then random keypad traffic against a queue-based model.
module tb_atm_pin_entry;

  localparam int PD   = 4;
  localparam int MT   = 3;
  localparam int TO   = 30;
  localparam int CODE = 'h1234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       card_clr = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] pin_out;
  logic       pin_ok, pin_bad, locked, busy;
  logic [2:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;

  atm_pin_entry #(
    .PIN_DIGITS (PD),
    .PIN_CODE   (16'h1234),
    .MAX_TRIES  (MT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .card_clr (card_clr),
    .key_valid(key_valid),
    .key_code (key_code),
    .pin_out  (pin_out),
    .pin_ok   (pin_ok),
    .pin_bad  (pin_bad),
    .locked   (locked),
    .busy     (busy),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 waiting, 1 entering, 2 judging, 3 locked out.
  int   m_phase;
  int   q[$];
  int   m_idle;
  int   m_tries;
  bit   m_timeout;
  logic [3:0] e_po;
  bit   e_ok, e_bad, e_lk, e_busy;
  int   e_cnt;

  function automatic void model_reset();
    m_phase = 0; q.delete(); m_idle = 0; m_tries = 0; m_timeout = 0;
    e_po = 4'h0; e_ok = 0; e_bad = 0; e_lk = 0; e_busy = 0; e_cnt = 0;
  endfunction

  function automatic int code_digit(int idx);
    return (CODE >> (4 * (PD - 1 - idx))) & 15;
  endfunction

  function automatic void model_step(bit st, bit cc, bit kv, int kc);
    bit accepted;
    int value;
    e_ok = 0; e_bad = 0;
    if (cc) begin
      m_phase = 0; q.delete(); m_tries = 0; m_timeout = 0; e_po = 4'h0;
    end else begin
      case (m_phase)
        0: if (st) begin
          m_phase = 1; q.delete(); m_idle = 0; m_timeout = 0; e_po = 4'h0;
        end
        1: begin
          accepted = 0;
          if (kv) begin
            if (kc <= 9 && q.size() < PD) begin
              q.push_back(kc); accepted = 1;
            end else if (kc == 10) begin
              q.delete(); accepted = 1;
            end else if (kc == 11 && q.size() == PD) begin
              m_phase = 2; accepted = 1;
            end
          end
          if (accepted) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TO) begin m_phase = 2; m_timeout = 1; end
          end
        end
        2: begin
          value = 0;
          foreach (q[i]) value = value * 16 + q[i];
          if (!m_timeout && q.size() == PD && value == CODE) begin
            e_ok = 1; e_po = 4'hF; m_tries = 0; m_phase = 0;
          end else begin
            e_bad = 1;
            if (m_tries < MT) m_tries++;
            m_phase = (m_tries == MT) ? 3 : 0;
          end
          q.delete(); m_timeout = 0;
        end
        default: if (st) e_bad = 1;
      endcase
    end
    e_lk   = (m_phase == 3);
    e_busy = (m_phase == 1 || m_phase == 2);
    e_cnt  = q.size();
  endfunction

  task automatic cmp(input string nm, input logic [3:0] po, input bit ok, input bit bad,
                     input bit lk, input bit bs, input int cnt);
    vectors++;
    if (pin_out !== po || pin_ok !== ok || pin_bad !== bad || locked !== lk ||
        busy !== bs || digit_cnt !== 3'(cnt)) begin
      miscompares++;
      $display("FAIL %s @%0t: dut po=%h ok=%b bad=%b lk=%b busy=%b cnt=%0d, want po=%h ok=%b bad=%b lk=%b busy=%b cnt=%0d",
               nm, $time, pin_out, pin_ok, pin_bad, locked, busy, digit_cnt,
               po, ok, bad, lk, bs, cnt);
    end
  endtask

  task automatic chk1(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
    end
  endtask

  task automatic apply(input bit st, input bit cc, input bit kv, input logic [3:0] kc);
    start = st; card_clr = cc; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(st, cc, kv, int'(kc));
    #1;
    start = 0; card_clr = 0; key_valid = 0; key_code = 4'h0;
  endtask

  task automatic step(input string nm, input bit st, input bit cc, input bit kv, input logic [3:0] kc);
    apply(st, cc, kv, kc);
    cmp(nm, e_po, e_ok, e_bad, e_lk, e_busy, e_cnt);
  endtask

  task automatic key(input string nm, input logic [3:0] kc);
    step(nm, 0, 0, 1, kc);
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 0, 0, 0, 4'h0);
  endtask

  task automatic attempt(input string nm, input logic [15:0] digits);
    logic [15:0] d;
    d = digits;
    step(nm, 1, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) key(nm, d[15 - 4*i -: 4]);
    key(nm, 4'hB);
    idle(nm, 2);
  endtask

  typedef struct {
    bit st, cc, kv;
    logic [3:0] kc;
    logic [3:0] po;
    bit ok, bad, lk, bs;
    int cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int bad_at;
    int r, p, kc;
    bit st, cc, kv;

    tbl[0]  = '{1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 1, 4'h1, 4'h0, 0, 0, 0, 1, 1};
    tbl[2]  = '{0, 0, 1, 4'h2, 4'h0, 0, 0, 0, 1, 2};
    tbl[3]  = '{0, 0, 1, 4'h3, 4'h0, 0, 0, 0, 1, 3};
    tbl[4]  = '{0, 0, 1, 4'h4, 4'h0, 0, 0, 0, 1, 4};
    tbl[5]  = '{0, 0, 1, 4'hB, 4'h0, 0, 0, 0, 1, 4};
    tbl[6]  = '{0, 0, 0, 4'h0, 4'hF, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 4'h5, 4'hF, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 4'hA, 4'h0, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 4'h9, 4'h0, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 1, 1, 4'h9, 4'h0, 0, 0, 0, 0, 0};

    // Asynchronous reset state.
    #2 rst = 0;
    #6;
    model_reset();
    cmp("reset", 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1;

    // Basic match and the table of single-cycle behaviours.
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].cc, tbl[i].kv, tbl[i].kc);
      cmp($sformatf("table[%0d]", i), tbl[i].po, tbl[i].ok, tbl[i].bad,
          tbl[i].lk, tbl[i].bs, tbl[i].cnt);
    end

    // Clear, short enter, overflow digits ignored when full.
    step("t2_start", 1, 0, 0, 4'h0);
    key("t2", 4'h1); key("t2", 4'h2); key("t2", 4'h9); key("t2", 4'hA);
    key("t2", 4'h3); key("t2", 4'h4); key("t2", 4'hB);
    chk1("t2_short_enter_busy", busy, 1);
    key("t2", 4'hA);
    key("t2", 4'h1); key("t2", 4'h2); key("t2", 4'h3); key("t2", 4'h4);
    key("t2", 4'h5); key("t2", 4'h6); key("t2", 4'hC);
    chk1("t2_full_cnt", digit_cnt, 4);
    key("t2", 4'hB);
    idle("t2", 1);
    chk1("t2_ok", pin_ok, 1);
    idle("t2", 1);
    chk1("t2_pin_hold", pin_out, 15);

    // Three failures lock the card; a further start pulses pin_bad only.
    attempt("t3", 16'h9999);
    attempt("t3", 16'h9999);
    attempt("t3", 16'h9999);
    chk1("t3_locked", locked, 1);
    step("t3_start_locked", 1, 0, 0, 4'h0);
    chk1("t3_lock_bad", pin_bad, 1);
    chk1("t3_lock_busy", busy, 0);
    idle("t3", 2);

    // Inter-key timeout after one digit.
    step("t4_clr", 0, 1, 0, 4'h0);
    step("t4_start", 1, 0, 0, 4'h0);
    key("t4", 4'h1);
    bad_at = -1;
    for (int i = 1; i <= TO + 3; i++) begin
      step("t4_idle", 0, 0, 0, 4'h0);
      if (pin_bad && bad_at < 0) bad_at = i;
    end
    chk1("t4_timeout_cycle", bad_at, TO + 1);
    chk1("t4_not_locked", locked, 0);
    attempt("t4", 16'h5555);
    attempt("t4", 16'h5555);
    chk1("t4_tries_carried", locked, 1);

    // card_clr from LOCK and from mid-entry.
    step("t5_clr", 0, 1, 0, 4'h0);
    chk1("t5_unlock", locked, 0);
    step("t5_start", 1, 0, 0, 4'h0);
    key("t5", 4'h1); key("t5", 4'h2);
    chk1("t5_cnt2", digit_cnt, 2);
    step("t5_clr_mid", 0, 1, 1, 4'h3);
    chk1("t5_cnt0", digit_cnt, 0);
    chk1("t5_busy0", busy, 0);
    attempt("t5", 16'h1234);
    chk1("t5_pin_out", pin_out, 15);

    // Asynchronous reset mid-entry, then a fresh attempt.
    step("t6_start", 1, 0, 0, 4'h0);
    key("t6", 4'h1); key("t6", 4'h2);
    #2 rst = 0;
    #1;
    model_reset();
    cmp("t6_async_reset", 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1;
    attempt("t6", 16'h1234);
    chk1("t6_pin_out", pin_out, 15);

    // Random keypad traffic biased toward typing the right PIN.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      st = (r < 8);
      cc = ($urandom_range(0, 199) == 0);
      kv = ($urandom_range(0, 99) < 45);
      p  = $urandom_range(0, 99);
      if (p < 65)      kc = (q.size() < PD) ? code_digit(q.size()) : 11;
      else if (p < 75) kc = 11;
      else if (p < 80) kc = 10;
      else if (p < 90) kc = $urandom_range(0, 9);
      else             kc = $urandom_range(0, 15);
      step("random", st, cc, kv, 4'(kc));
      if ($urandom_range(0, 299) == 0) idle("random_quiet", TO + 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
